commutator_route_ctrl: RTL and testbench
========================================

// Module: commutator_route_ctrl
// PURPOSE
//  Upstream sequencer for the 5-to-3 commutator datapath. Converts route requests
//  (output channel, source index) into the bit-reversed 3-bit select code and
//  one-hot latch strobes. Strobes go to the three transparent select-latch banks.
//  Keeps code stable around each strobe so transparent latches never capture glitches.
//  Optional scan mode rotates all three channels through the eight sources.
// PARAMETERS
//  STROBE_CYCLES  2    cycles the latch strobe is held high (>=1)
//  SCAN_PERIOD    16   cycles between scan steps (>=8, counts from end of last step)
// PORTS
//  clk            in   1  single system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  req_valid      in   1  route request valid
//  req_ready      out  1  controller can accept a request this cycle
//  req_chan       in   2  target output channel, 0..2 legal
//  req_src        in   3  source index 0..7 (natural binary)
//  scan_en        in   1  enable automatic rotation when no request pending
//  ctrl_code      out  3  select code to latch banks, bit-reversed {src[0],src[1],src[2]}
//  ctrl_load      out  3  one-hot latch strobe, bit k -> channel k bank
//  route_map      out  9  shadow of programmed routes, natural binary, chan k at [3k+2:3k]
//  busy           out  1  FSM not in IDLE
//  err_chan       out  1  sticky: request with req_chan==3 seen; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, ctrl_code=0, ctrl_load=0, route_map=0, err_chan=0.
//   Scan base=0, scan channel pointer=0, period counter=0. Reset mid-strobe drops
//   ctrl_load immediately; the datapath latches keep whatever they last held.
//  Handshake: transfer when req_valid & req_ready. req_ready=1 only in IDLE.
//   req_ready does not depend combinationally on req_valid.
//  Encoding: ctrl_code = {src[0],src[1],src[2]}; e.g. src=1 -> 3'b100, src=6 -> 3'b011.
//  FSM, all outputs registered:
//   IDLE   - on transfer with req_chan<=2: register chan/src, go SETUP.
//            req_chan==3: set err_chan, stay IDLE (request consumed, no strobe).
//            else, when scan_en & counter==SCAN_PERIOD-1: load next scan step, go SETUP.
//   SETUP  - 1 cycle: ctrl_code driven with new code, ctrl_load=0. Go STROBE.
//   STROBE - STROBE_CYCLES cycles: ctrl_load[chan]=1, code held. Go HOLD.
//   HOLD   - 1 cycle: ctrl_load=0, code held. Update route_map[chan]=src. Go IDLE.
//  Latency: request accepted in cycle T; strobe high T+2..T+1+STROBE_CYCLES;
//   route_map updates at T+2+STROBE_CYCLES; req_ready high again in the following cycle.
//  ctrl_code changes only on the IDLE->SETUP transition; otherwise it holds its last value.
//  Scan mode:
//   - step loads chan=ptr, src=(base+ptr) mod 8.
//   - ptr advances 0->1->2->0; base increments mod 8 when ptr wraps 2->0.
//   - period counter runs only in IDLE with scan_en=1; clears when a step is launched,
//     when scan_en=0, and on any transfer.
//  Priority: a valid request in IDLE beats a due scan step. The scan step is deferred,
//   counter held at SCAN_PERIOD-1, and launched at the next IDLE cycle with no request.
//  Deasserting scan_en mid-sequence completes the current step; no further steps launch.
// TESTING
//  1 Reset release, idle 10 cycles -> ctrl_load=0, ctrl_code=0, route_map=0, req_ready=1.
//  2 Request chan=1 src=1 at T, STROBE_CYCLES=2 ->
//     ctrl_code=3'b100 from T+1; ctrl_load=3'b010 at T+2,T+3; route_map[5:3]=1 at T+4.
//  3 Request chan=3 src=5 -> err_chan=1, no ctrl_load pulse, route_map unchanged,
//     req_ready=1 next cycle.
//  4 scan_en=1 for 3*(SCAN_PERIOD+4) cycles -> strobes on ch0,1,2 with src 0,1,2.
//     Next ch0 step uses src=1 (base=1).
//  5 Scan step due while req_valid held (chan=2 src=7) -> request strobed first,
//     scan step launched immediately after return to IDLE.
//  6 Drop rst_n during STROBE -> ctrl_load=0 same cycle, all outputs at reset values,
//     req_ready=1 after release.

Source files
------------

// File: rtl/commutator_route_ctrl.sv
// Route sequencer for the 5-to-3 commutator: turns (channel, source) requests or
// automatic scan steps into a bit-reversed select code plus one-hot latch strobes.
module commutator_route_ctrl #(
  parameter int STROBE_CYCLES = 2,
  parameter int SCAN_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_chan,
  input  logic [2:0] req_src,
  input  logic       scan_en,
  output logic [2:0] ctrl_code,
  output logic [2:0] ctrl_load,
  output logic [8:0] route_map,
  output logic       busy,
  output logic       err_chan
);

  localparam int SCW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int STW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SCW-1:0] SCAN_LAST   = SCW'(SCAN_PERIOD - 1);
  localparam logic [STW-1:0] STROBE_LAST = STW'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state_reg;
  logic [1:0]       chan_reg;
  logic [2:0]       src_reg;
  logic [STW-1:0]   strobe_cnt_reg;
  logic [SCW-1:0]   scan_cnt_reg;
  logic [1:0]       scan_ptr_reg;
  logic [2:0]       scan_base_reg;
  logic [2:0]       ctrl_code_reg;
  logic [2:0]       ctrl_load_reg;
  logic             err_chan_reg;

  logic [2:0]       chan_onehot;
  logic [2:0]       scan_src;
  logic             scan_due;
  logic             strobe_last;

  function automatic logic [2:0] bitrev3(input logic [2:0] s);
    return {s[0], s[1], s[2]};
  endfunction

  assign scan_src    = scan_base_reg + {1'b0, scan_ptr_reg};
  assign scan_due    = scan_en && (scan_cnt_reg == SCAN_LAST);
  assign strobe_last = (state_reg == STROBE) && (strobe_cnt_reg == STROBE_LAST);

  // Per-channel decode and shadow bank; a bank commits as its strobe ends.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [2:0] bank_reg;

      assign chan_onehot[gi] = (chan_reg == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_reg <= '0;
        end else if (strobe_last && chan_onehot[gi]) begin
          bank_reg <= src_reg;
        end
      end

      assign route_map[3*gi +: 3] = bank_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      chan_reg       <= '0;
      src_reg        <= '0;
      strobe_cnt_reg <= '0;
      scan_cnt_reg   <= '0;
      scan_ptr_reg   <= '0;
      scan_base_reg  <= '0;
      ctrl_code_reg  <= '0;
      ctrl_load_reg  <= '0;
      err_chan_reg   <= 1'b0;
    end else begin
      if (!scan_en) begin
        scan_cnt_reg <= '0;
      end
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            // A due scan step is deferred, not dropped: keep the counter parked.
            if (!scan_due) begin
              scan_cnt_reg <= '0;
            end
            if (req_chan == 2'd3) begin
              err_chan_reg <= 1'b1;
            end else begin
              chan_reg      <= req_chan;
              src_reg       <= req_src;
              ctrl_code_reg <= bitrev3(req_src);
              state_reg     <= SETUP;
            end
          end else if (scan_due) begin
            chan_reg      <= scan_ptr_reg;
            src_reg       <= scan_src;
            ctrl_code_reg <= bitrev3(scan_src);
            scan_cnt_reg  <= '0;
            state_reg     <= SETUP;
            if (scan_ptr_reg == 2'd2) begin
              scan_ptr_reg  <= 2'd0;
              scan_base_reg <= scan_base_reg + 3'd1;
            end else begin
              scan_ptr_reg <= scan_ptr_reg + 2'd1;
            end
          end else if (scan_en) begin
            scan_cnt_reg <= scan_cnt_reg + SCW'(1);
          end
        end
        SETUP: begin
          ctrl_load_reg  <= chan_onehot;
          strobe_cnt_reg <= '0;
          state_reg      <= STROBE;
        end
        STROBE: begin
          if (strobe_last) begin
            ctrl_load_reg <= '0;
            state_reg     <= HOLD;
          end else begin
            strobe_cnt_reg <= strobe_cnt_reg + STW'(1);
          end
        end
        HOLD: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign ctrl_code = ctrl_code_reg;
  assign ctrl_load = ctrl_load_reg;
  assign err_chan  = err_chan_reg;

endmodule

// File: tb/tb_commutator_route_ctrl.sv
// Directed bench for commutator_route_ctrl: requests, illegal channel, scan rotation,
// request-vs-scan priority and reset during a strobe.
module tb_commutator_route_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_chan;
  logic [2:0] req_src;
  logic       scan_en;
  logic [2:0] ctrl_code;
  logic [2:0] ctrl_load;
  logic [8:0] route_map;
  logic       busy;
  logic       err_chan;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] exp_load [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0] exp_code [4] = '{3'b000, 3'b100, 3'b010, 3'b100};
  logic [2:0] load_seen;

  commutator_route_ctrl #(.STROBE_CYCLES(2), .SCAN_PERIOD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_chan  (req_chan),
    .req_src   (req_src),
    .scan_en   (scan_en),
    .ctrl_code (ctrl_code),
    .ctrl_load (ctrl_load),
    .route_map (route_map),
    .busy      (busy),
    .err_chan  (err_chan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_chan  = 2'd0;
    req_src   = 3'd0;
    scan_en   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(10);

    $display("idle after reset");
    check("rst_load", 9'(ctrl_load), 9'd0);
    check("rst_code", 9'(ctrl_code), 9'd0);
    check("rst_map", route_map, 9'd0);
    check("rst_ready", 9'(req_ready), 9'd1);
    check("rst_busy", 9'(busy), 9'd0);
    check("rst_err", 9'(err_chan), 9'd0);

    $display("req chan=1 src=1");
    req_valid = 1'b1; req_chan = 2'd1; req_src = 3'd1;
    check("t0_ready", 9'(req_ready), 9'd1);
    tick(1); req_valid = 1'b0;
    check("t1_code", 9'(ctrl_code), 9'b100);
    check("t1_load", 9'(ctrl_load), 9'd0);
    check("t1_ready", 9'(req_ready), 9'd0);
    check("t1_busy", 9'(busy), 9'd1);
    tick(1);
    check("t2_load", 9'(ctrl_load), 9'b010);
    check("t2_map", route_map, 9'd0);
    tick(1);
    check("t3_load", 9'(ctrl_load), 9'b010);
    check("t3_code", 9'(ctrl_code), 9'b100);
    tick(1);
    check("t4_load", 9'(ctrl_load), 9'd0);
    check("t4_map", route_map, 9'h008);
    check("t4_ready", 9'(req_ready), 9'd0);
    tick(1);
    check("t5_ready", 9'(req_ready), 9'd1);
    check("t5_busy", 9'(busy), 9'd0);
    check("t5_code", 9'(ctrl_code), 9'b100);

    $display("req chan=3 src=5 (illegal)");
    req_valid = 1'b1; req_chan = 2'd3; req_src = 3'd5;
    tick(1); req_valid = 1'b0;
    check("bad_err", 9'(err_chan), 9'd1);
    check("bad_ready", 9'(req_ready), 9'd1);
    check("bad_load", 9'(ctrl_load), 9'd0);
    check("bad_busy", 9'(busy), 9'd0);
    tick(3);
    check("bad_load_later", 9'(ctrl_load), 9'd0);
    check("bad_map", route_map, 9'h008);
    check("bad_err_sticky", 9'(err_chan), 9'd1);

    scan_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick((k == 0) ? 17 : 20);
      $display("scan step %0d load=%b code=%b", k, ctrl_load, ctrl_code);
      check($sformatf("scan%0d_load", k), 9'(ctrl_load), 9'(exp_load[k]));
      check($sformatf("scan%0d_code", k), 9'(ctrl_code), 9'(exp_code[k]));
    end
    tick(3);
    check("scan_map", route_map, 9'h089);
    check("scan_idle", 9'(busy), 9'd0);
    scan_en = 1'b0;

    tick(1);
    scan_en = 1'b1;
    tick(15);
    $display("req chan=2 src=7 against due scan step");
    req_valid = 1'b1; req_chan = 2'd2; req_src = 3'd7;
    check("prio_ready", 9'(req_ready), 9'd1);
    tick(1); req_valid = 1'b0;
    check("prio_code", 9'(ctrl_code), 9'b111);
    check("prio_busy", 9'(busy), 9'd1);
    tick(1);
    check("prio_load", 9'(ctrl_load), 9'b100);
    tick(2);
    check("prio_hold_load", 9'(ctrl_load), 9'd0);
    check("prio_map", route_map, 9'h1C9);
    tick(1);
    check("prio_back_idle", 9'(req_ready), 9'd1);
    tick(1);
    check("deferred_code", 9'(ctrl_code), 9'b010);
    check("deferred_busy", 9'(busy), 9'd1);
    scan_en = 1'b0;
    tick(1);
    check("deferred_load", 9'(ctrl_load), 9'b010);
    tick(2);
    check("deferred_map", route_map, 9'h1D1);
    load_seen = 3'd0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      load_seen = load_seen | ctrl_load;
    end
    check("scan_off_quiet", 9'(load_seen), 9'd0);

    $display("req chan=0 src=3 then reset mid-strobe");
    req_valid = 1'b1; req_chan = 2'd0; req_src = 3'd3;
    tick(1); req_valid = 1'b0;
    tick(1);
    check("pre_rst_load", 9'(ctrl_load), 9'b001);
    #2 rst_n = 1'b0;
    #1;
    check("arst_load", 9'(ctrl_load), 9'd0);
    check("arst_code", 9'(ctrl_code), 9'd0);
    check("arst_map", route_map, 9'd0);
    check("arst_err", 9'(err_chan), 9'd0);
    check("arst_busy", 9'(busy), 9'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    check("post_rst_ready", 9'(req_ready), 9'd1);
    check("post_rst_load", 9'(ctrl_load), 9'd0);
    check("post_rst_map", route_map, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
